// File: rtl/addsub_register.sv
// Registered adder/subtractor with carry/borrow chaining and signed-overflow flag.
// Define ADDSUB_REGISTER_CARRIES_EN to build the per-bit carries register; otherwise carries reads zero.
module addsub_register #(
  parameter int unsigned            WORD_WIDTH  = 20,
  parameter logic [WORD_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  clock_enable,
  input  logic                  add_sub,
  input  logic                  carry_in,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic [WORD_WIDTH-1:0] carries,
  output logic                  overflow
);

  logic [WORD_WIDTH-1:0] bx;
  logic                  cin;
  logic [WORD_WIDTH-1:0] s;
  logic                  c;
  logic                  msb_carry;

  // Subtraction is A + ~B + ~borrow_in; carry_out is re-inverted to read as a borrow.
  always_comb begin
    bx        = B ^ {WORD_WIDTH{add_sub}};
    cin       = carry_in ^ add_sub;
    {c, s}    = {1'b0, A} + {1'b0, bx} + {{WORD_WIDTH{1'b0}}, cin};
    msb_carry = A[WORD_WIDTH-1] ^ bx[WORD_WIDTH-1] ^ s[WORD_WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sum       <= RESET_VALUE;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (clock_enable) begin
      sum       <= s;
      carry_out <= c ^ add_sub;
      overflow  <= msb_carry ^ c;
    end
  end

`ifdef ADDSUB_REGISTER_CARRIES_EN
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      carries <= '0;
    end else if (clock_enable) begin
      carries <= A ^ bx ^ s;
    end
  end
`else
  assign carries = '0;
`endif

endmodule

// File: tb/tb_addsub_register.sv
// Self-checking bench for addsub_register (W=8): constant vector table, hold/reset sequences,
// then random traffic checked against an integer-arithmetic model through a scoreboard queue.
module tb_addsub_register;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         clock_enable = 1'b0;
  logic         add_sub = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic [W-1:0] carries;
  logic         overflow;

  int unsigned checks = 0;
  int unsigned passes = 0;

  addsub_register #(.WORD_WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clock(clock), .clear_n(clear_n), .clock_enable(clock_enable),
    .add_sub(add_sub), .carry_in(carry_in), .A(A), .B(B),
    .sum(sum), .carry_out(carry_out), .carries(carries), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic [W-1:0] car;
    logic         ovf;
  } out_t;

  typedef struct {
    logic         clr_n;
    logic         ce;
    logic         as;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    out_t         exp;
  } vec_t;

  out_t exp_q[$];
  out_t prev = '{8'h00, 1'b0, 8'h00, 1'b0};

  // Independent reference: plain integer arithmetic for sum/flags, prefix sums for carries.
  function automatic out_t model(logic as, logic cin, logic [W-1:0] a, logic [W-1:0] b);
    out_t r;
    int   d, sv, mask, part;
    logic [W-1:0] bxm;
    logic cx;
    if (!as) begin
      d  = int'(a) + int'(b) + int'(cin);
      sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
      r.co = d > 255;
    end else begin
      d  = int'(a) - int'(b) - int'(cin);
      sv = int'($signed(a)) - int'($signed(b)) - int'(cin);
      r.co = d < 0;
    end
    r.sum = d[W-1:0];
    r.ovf = (sv > 127) || (sv < -128);
    bxm = as ? ~b : b;
    cx  = cin ^ as;
    r.car = '0;
    r.car[0] = cx;
    for (int i = 1; i < int'(W); i++) begin
      mask = (1 << i) - 1;
      part = (int'(a) & mask) + (int'(bxm) & mask) + int'(cx);
      r.car[i] = part[i];
    end
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the capturing edge.
  task automatic apply(logic clr_n, logic ce, logic as, logic cin,
                       logic [W-1:0] a, logic [W-1:0] b, out_t e);
    out_t got;
    @(negedge clock);
    clear_n = clr_n; clock_enable = ce; add_sub = as; carry_in = cin; A = a; B = b;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
`ifdef ADDSUB_REGISTER_CARRIES_EN
    check("carries", carries, got.car);
`else
    check("carries", carries, 8'h00);
`endif
    check("sum", sum, got.sum);
    check("carry_out", {7'b0, carry_out}, {7'b0, got.co});
    check("overflow", {7'b0, overflow}, {7'b0, got.ovf});
    prev = got;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, '{8'h00, 1'b0, 8'h00, 1'b0}};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h01, '{8'h80, 1'b0, 8'hFE, 1'b1}};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, '{8'h00, 1'b1, 8'hFE, 1'b0}};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, '{8'hFF, 1'b1, 8'h01, 1'b0}};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h01, '{8'h7F, 1'b0, 8'h01, 1'b1}};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, '{8'h7F, 1'b0, 8'h01, 1'b1}};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, '{8'h31, 1'b0, 8'h01, 1'b0}};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h01, '{8'h0E, 1'b0, 8'hE0, 1'b0}};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, '{8'h00, 1'b0, 8'h00, 1'b0}};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 8'hFF, 1'b0}};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h80, '{8'hFF, 1'b1, 8'hFF, 1'b1}};

    foreach (vecs[i])
      apply(vecs[i].clr_n, vecs[i].ce, vecs[i].as, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Multi-cycle hold: several disabled edges with changing operands.
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'b0, i[0], ~i[0], 8'h3C + 8'(i), 8'hC3, prev);

    // Reset while disabled still clears, then resume from a fresh capture.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, '{8'h00, 1'b0, 8'h00, 1'b0});
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, model(1'b1, 1'b1, 8'h00, 8'h00));

    // Randomised traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic rc, re, ras, rci;
      logic [W-1:0] ra, rb;
      out_t e;
      rc  = ($urandom_range(0, 15) != 0);
      re  = ($urandom_range(0, 3) != 0);
      ras = 1'($urandom);
      rci = 1'($urandom);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (!rc)     e = '{8'h00, 1'b0, 8'h00, 1'b0};
      else if (re) e = model(ras, rci, ra, rb);
      else         e = prev;
      apply(rc, re, ras, rci, ra, rb, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
